// File: rtl/axi_slave_rd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : axi_slave_rd_engine                                         |
// | AXI3 read-slave engine: AR requests are queued and replayed as R     |
// | bursts after a minimum latency. WRAP support: AXI_SLAVE_RD_WRAP_EN.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 128
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 8
`endif

module axi_slave_rd_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH,
    parameter int QDEPTH_LG2 = 4,
    parameter int AR2R_DELAY = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid_i,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [3:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    output logic                  arready_o,
    output logic                  rvalid_o,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    input  logic                  rready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [QDEPTH_LG2:0]   occupancy_o
);

    localparam int                  c_DEPTH    = 1 << QDEPTH_LG2;
    localparam int                  c_MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam logic [15:0]         c_DELAY    = 16'(AR2R_DELAY);
    localparam logic [QDEPTH_LG2:0] c_FULL     = (QDEPTH_LG2 + 1)'(c_DEPTH);
    localparam logic [QDEPTH_LG2:0] c_ONE      = (QDEPTH_LG2 + 1)'(1);
    localparam logic [QDEPTH_LG2-1:0] c_PTR_ONE = QDEPTH_LG2'(1);
    localparam logic [1:0]          c_FIXED    = 2'b00;
    localparam logic [1:0]          c_WRAP     = 2'b10;
    localparam logic [1:0]          c_RSVD     = 2'b11;
    localparam logic [1:0]          c_OKAY     = 2'b00;
    localparam logic [1:0]          c_SLVERR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [15:0]           snap;
    } ar_entry_t;

    ar_entry_t               r_queue [c_DEPTH];
    logic [QDEPTH_LG2-1:0]   r_wr_ptr;
    logic [QDEPTH_LG2-1:0]   r_rd_ptr;
    logic [QDEPTH_LG2:0]     r_count;
    logic [15:0]             r_cycle;
    logic [3:0]              r_beat;
    state_t                  r_state;
    state_t                  w_state_nx;

    ar_entry_t               w_new;
    ar_entry_t               w_head;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fire;
    logic                    w_last;
    logic                    w_due;
    logic                    w_size_err;
    logic                    w_slverr;
    logic [15:0]             w_elapsed;
    logic [ADDR_WIDTH-1:0]   w_step;
    logic [ADDR_WIDTH-1:0]   w_incr_addr;
    logic [ADDR_WIDTH-1:0]   w_beat_addr;

    assign w_head     = r_queue[r_rd_ptr];
    assign w_last     = (r_beat == w_head.len);
    assign w_fire     = (r_state == ST_BURST) && rready_i;
    assign w_pop      = w_fire && w_last;
    // A full queue still takes a new request in the cycle its head retires.
    assign arready_o  = (r_count != c_FULL) || w_pop;
    assign w_push     = arvalid_i && arready_o;
    assign w_elapsed  = r_cycle - w_head.snap;
    assign w_due      = (w_elapsed >= c_DELAY);
    assign occupancy_o = r_count;

    always_comb begin
        w_new       = '0;
        w_new.id    = arid_i;
        w_new.addr  = araddr_i;
        w_new.len   = arlen_i;
        w_new.size  = arsize_i;
        w_new.burst = arburst_i;
        w_new.snap  = r_cycle;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cycle  <= '0;
            r_beat   <= '0;
            r_state  <= ST_IDLE;
        end else begin
            r_cycle <= r_cycle + 16'd1;
            r_state <= w_state_nx;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_ONE;
            end
            if (w_fire) begin
                r_beat <= w_last ? 4'd0 : (r_beat + 4'd1);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_due) begin
                    w_state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_pop) begin
                    w_state_nx = ((r_count > c_ONE) || w_push) ? ST_WAIT : ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_size_err  = (w_head.size > 3'(c_MAX_SIZE));
    assign w_step      = ADDR_WIDTH'(r_beat) << w_head.size;
    assign w_incr_addr = w_head.addr + w_step;

`ifdef AXI_SLAVE_RD_WRAP_EN
    logic                  w_wrap_len_ok;
    logic                  w_wrap_mode;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [ADDR_WIDTH-1:0] w_wrap_addr;

    assign w_wrap_len_ok = (w_head.len == 4'd1) || (w_head.len == 4'd3) ||
                           (w_head.len == 4'd7) || (w_head.len == 4'd15);
    assign w_wrap_mode   = (w_head.burst == c_WRAP) && w_wrap_len_ok && !w_size_err;
    assign w_slverr      = (w_head.burst == c_RSVD) || w_size_err ||
                           ((w_head.burst == c_WRAP) && !w_wrap_len_ok);
    // Container size is a power of two, so wrapping is a mask inside an aligned window.
    assign w_wrap_mask   = ((ADDR_WIDTH'(w_head.len) + ADDR_WIDTH'(1)) << w_head.size)
                           - ADDR_WIDTH'(1);
    assign w_size_mask   = (ADDR_WIDTH'(1) << w_head.size) - ADDR_WIDTH'(1);
    assign w_aligned     = w_head.addr & ~w_size_mask;
    assign w_wrap_addr   = (w_head.addr & ~w_wrap_mask) |
                           ((w_aligned + w_step) & w_wrap_mask);
`else
    assign w_slverr      = (w_head.burst == c_RSVD) || w_size_err ||
                           (w_head.burst == c_WRAP);
`endif

    always_comb begin
        w_beat_addr = w_incr_addr;
        if (w_head.burst == c_FIXED) begin
            w_beat_addr = w_head.addr;
        end
`ifdef AXI_SLAVE_RD_WRAP_EN
        // First WRAP beat keeps the requested (possibly unaligned) address.
        else if (w_wrap_mode) begin
            w_beat_addr = (r_beat == 4'd0) ? w_head.addr : w_wrap_addr;
        end
`endif
    end

    always_comb begin
        rvalid_o   = 1'b0;
        rid_o      = '0;
        rresp_o    = c_OKAY;
        rlast_o    = 1'b0;
        mem_addr_o = '0;
        if (r_state == ST_BURST) begin
            rvalid_o   = 1'b1;
            rid_o      = w_head.id;
            rresp_o    = w_slverr ? c_SLVERR : c_OKAY;
            rlast_o    = w_last;
            mem_addr_o = w_beat_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_rd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_axi_slave_rd_engine                                      |
// | Directed bench for axi_slave_rd_engine: vector table plus sequences. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

module tb_axi_slave_rd_engine;

    localparam int AW  = 16;
    localparam int DW  = 128;
    localparam int IW  = 8;
    localparam int QL  = 4;
    localparam int DLY = 50;
    localparam int NV  = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arvalid;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arready;
    logic          rvalid;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rready;
    logic [AW-1:0] mem_addr;
    logic [QL:0]   occupancy;

    always #5 clk = ~clk;

    axi_slave_rd_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .QDEPTH_LG2 (QL),
        .AR2R_DELAY (DLY)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arvalid_i   (arvalid),
        .arid_i      (arid),
        .araddr_i    (araddr),
        .arlen_i     (arlen),
        .arsize_i    (arsize),
        .arburst_i   (arburst),
        .arready_o   (arready),
        .rvalid_o    (rvalid),
        .rid_o       (rid),
        .rresp_o     (rresp),
        .rlast_o     (rlast),
        .rready_i    (rready),
        .mem_addr_o  (mem_addr),
        .occupancy_o (occupancy)
    );

    typedef struct packed {
        logic [IW-1:0]         id;
        logic [1:0]            burst;
        logic [AW-1:0]         addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            resp;
        logic                  chk_addr;
        logic [0:15][AW-1:0]   exp_addr;
    } vec_t;

    vec_t vec [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        for (int i = 0; i < 100; i++) begin
            if (arready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        chk($sformatf("ar_accept_id%0d", id), 32'(ok), 32'd1);
    endtask

    task automatic wait_rvalid(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            #1;
            if (rvalid) break;
        end
    endtask

    task automatic run_vector(input int i);
        int lat;
        issue_ar(vec[i].id, vec[i].addr, vec[i].len, vec[i].size, vec[i].burst);
        wait_rvalid(lat);
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(DLY));
        for (int b = 0; b <= int'(vec[i].len); b++) begin
            chk($sformatf("v%0d_b%0d_rvalid", i, b), 32'(rvalid), 32'd1);
            if (vec[i].chk_addr)
                chk($sformatf("v%0d_b%0d_addr", i, b), 32'(mem_addr), 32'(vec[i].exp_addr[b]));
            chk($sformatf("v%0d_b%0d_rresp", i, b), 32'(rresp), 32'(vec[i].resp));
            chk($sformatf("v%0d_b%0d_rlast", i, b), 32'(rlast), 32'(b == int'(vec[i].len)));
            chk($sformatf("v%0d_b%0d_rid", i, b), 32'(rid), 32'(vec[i].id));
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d_idle_after", i), 32'(rvalid), 32'd0);
    endtask

    logic [IW-1:0] got [17];
    int            ngot;
    int            n;
    int            lat;

    initial begin
        // {id, burst, addr, len, size, resp, chk_addr, expected beat addresses}
        vec[0] = '{id:8'h01, burst:2'b01, addr:16'h0100, len:4'd3, size:3'd4, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'h0100, 16'h0110, 16'h0120, 16'h0130, {12{16'h0}}}};
        vec[1] = '{id:8'h02, burst:2'b00, addr:16'h0040, len:4'd2, size:3'd2, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'h0040, 16'h0040, 16'h0040, {13{16'h0}}}};
        vec[2] = '{id:8'h03, burst:2'b11, addr:16'h0200, len:4'd3, size:3'd2, resp:2'b10, chk_addr:1'b0,
                   exp_addr:'0};
`ifdef AXI_SLAVE_RD_WRAP_EN
        vec[3] = '{id:8'h04, burst:2'b10, addr:16'h0034, len:4'd3, size:3'd3, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'h0034, 16'h0038, 16'h0020, 16'h0028, {12{16'h0}}}};
        vec[7] = '{id:8'h07, burst:2'b10, addr:16'h0108, len:4'd15, size:3'd2, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'h0108, 16'h010C, 16'h0110, 16'h0114, 16'h0118, 16'h011C, 16'h0120, 16'h0124,
                             16'h0128, 16'h012C, 16'h0130, 16'h0134, 16'h0138, 16'h013C, 16'h0100, 16'h0104}};
`else
        vec[3] = '{id:8'h04, burst:2'b10, addr:16'h0034, len:4'd3, size:3'd3, resp:2'b10, chk_addr:1'b1,
                   exp_addr:{16'h0034, 16'h003C, 16'h0044, 16'h004C, {12{16'h0}}}};
        vec[7] = '{id:8'h07, burst:2'b10, addr:16'h0108, len:4'd15, size:3'd2, resp:2'b10, chk_addr:1'b1,
                   exp_addr:{16'h0108, 16'h010C, 16'h0110, 16'h0114, 16'h0118, 16'h011C, 16'h0120, 16'h0124,
                             16'h0128, 16'h012C, 16'h0130, 16'h0134, 16'h0138, 16'h013C, 16'h0140, 16'h0144}};
`endif
        vec[4] = '{id:8'h05, burst:2'b01, addr:16'h1000, len:4'd1, size:3'd5, resp:2'b10, chk_addr:1'b0,
                   exp_addr:'0};
        vec[5] = '{id:8'h06, burst:2'b01, addr:16'hFFF0, len:4'd2, size:3'd4, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'hFFF0, 16'h0000, 16'h0010, {13{16'h0}}}};
        vec[6] = '{id:8'h08, burst:2'b10, addr:16'h0100, len:4'd2, size:3'd2, resp:2'b10, chk_addr:1'b1,
                   exp_addr:{16'h0100, 16'h0104, 16'h0108, {13{16'h0}}}};
        vec[8] = '{id:8'h09, burst:2'b01, addr:16'h0ABC, len:4'd0, size:3'd0, resp:2'b00, chk_addr:1'b1,
                   exp_addr:{16'h0ABC, {15{16'h0}}}};

        rst_n   = 1'b0;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd1);

        for (int i = 0; i < NV; i++) run_vector(i);

        // Backpressure: rready drops for 5 cycles while the third beat is presented.
        issue_ar(8'h11, 16'h0100, 4'd3, 3'd4, 2'b01);
        wait_rvalid(lat);
        chk("bp_latency", 32'(lat), 32'(DLY));
        chk("bp_b0_addr", 32'(mem_addr), 32'h0100);
        @(posedge clk); #1;
        chk("bp_b1_addr", 32'(mem_addr), 32'h0110);
        @(posedge clk); #1;
        rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_stall%0d_rvalid", c), 32'(rvalid), 32'd1);
            chk($sformatf("bp_stall%0d_addr", c), 32'(mem_addr), 32'h0120);
            chk($sformatf("bp_stall%0d_rid", c), 32'(rid), 32'h11);
            chk($sformatf("bp_stall%0d_rlast", c), 32'(rlast), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        chk("bp_b3_addr", 32'(mem_addr), 32'h0130);
        chk("bp_b3_rlast", 32'(rlast), 32'd1);
        @(posedge clk); #1;
        chk("bp_done", 32'(rvalid), 32'd0);

        // Queue full: 16 single-beat requests stall, the 17th rides in on the first pop.
        rready = 1'b0;
        for (int k = 0; k < 16; k++) issue_ar(8'(k), 16'(k * 16), 4'd0, 3'd2, 2'b01);
        chk("qf_occupancy16", 32'(occupancy), 32'd16);
        chk("qf_arready_low", 32'(arready), 32'd0);
        @(negedge clk);
        arvalid = 1'b1;
        arid    = 8'd16;
        araddr  = 16'h0500;
        arlen   = 4'd0;
        arsize  = 3'd2;
        arburst = 2'b01;
        n = 0;
        while (!rvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("qf_head_valid", 32'(rvalid), 32'd1);
        chk("qf_blocked_arready", 32'(arready), 32'd0);
        chk("qf_blocked_occ", 32'(occupancy), 32'd16);
        got[0] = rid;
        ngot   = 1;
        rready = 1'b1;
        #1;
        chk("qf_arready_on_pop", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("qf_occ_push_pop", 32'(occupancy), 32'd16);
        n = 0;
        while (ngot < 17 && n < 800) begin
            @(negedge clk);
            n++;
            if (rvalid) begin
                got[ngot] = rid;
                ngot++;
            end
        end
        chk("qf_beats", 32'(ngot), 32'd17);
        for (int k = 0; k < 17; k++) chk($sformatf("qf_order%0d", k), 32'(got[k]), 32'(k));
        @(posedge clk); #1;
        chk("qf_drained", 32'(occupancy), 32'd0);

        // Reset while beat 1 of an 8-beat burst is on the bus.
        issue_ar(8'h21, 16'h0300, 4'd7, 3'd2, 2'b01);
        wait_rvalid(lat);
        chk("mr_latency", 32'(lat), 32'(DLY));
        @(posedge clk); #1;
        chk("mr_b1_addr", 32'(mem_addr), 32'h0304);
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        chk("mr_occupancy", 32'(occupancy), 32'd0);
        chk("mr_rlast", 32'(rlast), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (rvalid) n++;
        end
        chk("mr_no_resume", 32'(n), 32'd0);
        issue_ar(8'h22, 16'h0400, 4'd0, 3'd2, 2'b01);
        wait_rvalid(lat);
        chk("mr_new_latency", 32'(lat), 32'(DLY));
        chk("mr_new_addr", 32'(mem_addr), 32'h0400);
        chk("mr_new_rid", 32'(rid), 32'h22);
        chk("mr_new_rlast", 32'(rlast), 32'd1);
        @(posedge clk); #1;
        chk("mr_new_done", 32'(rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_slave_rd_engine.md
AXI_SLAVE_RD_ENGINE -- requirements
Module: axi_slave_rd_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, R data width in bits (power of 2, >=32).
REQ-003 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH, AR/R ID width.
REQ-004 SHALL have parameter QDEPTH_LG2, default 4, log2 of AR queue entries.
REQ-005 SHALL have parameter AR2R_DELAY, default 50, minimum cycles from AR acceptance to first R beat (>=1).
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: arvalid_i in 1; arid_i in ID_WIDTH; araddr_i in ADDR_WIDTH; arlen_i in 4; arsize_i in 3; arburst_i in 2; arready_o out 1 -- AXI3 AR channel.
REQ-008 SHALL have ports: rvalid_o out 1; rid_o out ID_WIDTH; rresp_o out 2; rlast_o out 1; rready_i in 1 -- R control; rdata is driven by the memory model from mem_addr_o.
REQ-009 SHALL have ports: mem_addr_o out ADDR_WIDTH, byte address of current beat; occupancy_o out QDEPTH_LG2+1, queued AR entries.

Function
REQ-010 SHALL accept AR when arvalid_i && arready_o at rising clk; arready_o = queue not full (combinational from registered count).
REQ-011 SHALL store per entry: id, addr, len, size, burst, and a 16-bit snapshot of a free-running cycle counter at acceptance.
REQ-012 SHALL serve entries strictly in acceptance order, one burst at a time.
REQ-013 SHALL use FSM IDLE -> WAIT (queue non-empty) -> BURST (counter - snapshot >= AR2R_DELAY, modulo 2^16) -> BURST until last beat handshake -> WAIT if queue non-empty else IDLE.
REQ-014 SHALL assert rvalid_o only in BURST; rvalid_o, rid_o, rresp_o, rlast_o, mem_addr_o SHALL hold stable while rvalid_o && !rready_i.
REQ-015 SHALL advance beat on rvalid_o && rready_i; rlast_o = 1 on beat arlen (arlen+1 beats total).
REQ-016 SHALL pop the queue on the last-beat handshake; a simultaneous push and pop SHALL leave occupancy unchanged, and push SHALL be permitted when full and popping in the same cycle.
REQ-017 SHALL compute beat address: FIXED (00) = addr; INCR (01) = addr + beat*(1<<size), modulo 2^ADDR_WIDTH; WRAP (10) per REQ-024.
REQ-018 SHALL return rresp_o = 2'b00 (OKAY) except: arburst 11, or arsize > log2(DATA_WIDTH/8) -> 2'b10 (SLVERR) for all beats, full beat count still returned.
REQ-019 SHALL ignore arvalid_i when full (arready_o=0); no entry lost or duplicated.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear queue, pointers, FSM to IDLE, cycle counter to 0.
REQ-021 SHALL drive during/after reset: arready_o=1 (after release), rvalid_o=0, rlast_o=0, rid_o=0, rresp_o=0, mem_addr_o=0, occupancy_o=0.
REQ-022 SHALL discard any in-flight burst on mid-operation reset; no beats resume after release.

Configuration
REQ-023 SHALL gate WRAP support with macro AXI_SLAVE_RD_WRAP_EN.
REQ-024 With AXI_SLAVE_RD_WRAP_EN defined: WRAP length 2/4/8/16 beats; boundary = addr aligned down to (len+1)<<size; address wraps to boundary on reaching boundary+((len+1)<<size); other lengths -> SLVERR, INCR addressing.
REQ-025 Without AXI_SLAVE_RD_WRAP_EN: WRAP requests SHALL return SLVERR on every beat with INCR addressing.

Verification
REQ-026 Single INCR: addr 0x0100, len 3, size 4 (16B), rready=1 -> first rvalid exactly 50 cycles after accept; mem_addr 0x100,0x110,0x120,0x130; rlast on 4th beat; rresp 00.
REQ-027 Backpressure: rready low 5 cycles on beat 2 -> rvalid, rid, mem_addr, rlast stable all 5 cycles; 4 beats total, none skipped.
REQ-028 Queue full: 17 ARs, rready=0 -> arready_o=0 after 16th accept, occupancy_o=16; raise rready -> 17th accepted on first pop cycle; IDs returned in order 0..16.
REQ-029 WRAP (macro on): addr 0x0034, len 3, size 3 -> mem_addr 0x34,0x38,0x20,0x28 (boundary 0x20); macro off -> rresp 10 on all 4 beats.
REQ-030 FIXED and error: FIXED addr 0x0040 len 2 -> mem_addr 0x40 ×3; arburst 11 -> 4 beats, rresp 10, rlast on 4th.
REQ-031 Reset mid-burst at beat 1 of len 7 -> rvalid_o=0 immediately, occupancy_o=0; new AR after release served with fresh 50-cycle delay.
